// File: rtl/fcmp_pkg.sv
// +----------------------------------------------------------------------------+
// | fcmp_pkg : op codes, operand class encoding and classifier for fcmp_pipe    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package fcmp_pkg;

  typedef enum logic [2:0] {
    FCMP_FEQ  = 3'd0,
    FCMP_FLT  = 3'd1,
    FCMP_FLE  = 3'd2,
    FCMP_FMIN = 3'd3,
    FCMP_FMAX = 3'd4
  } fcmp_op_e;

  // Encoded so that a plain unsigned compare gives NEG < ZERO < POS.
  localparam logic [1:0] CLS_NEG  = 2'd0;
  localparam logic [1:0] CLS_ZERO = 2'd1;
  localparam logic [1:0] CLS_POS  = 2'd2;

  function automatic logic [1:0] fcmp_class(input logic sign, input logic exp_zero);
    if (exp_zero) return CLS_ZERO;
    return sign ? CLS_NEG : CLS_POS;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fcmp_core.sv
// +----------------------------------------------------------------------------+
// | fcmp_core : combinational FP compare/select (FEQ/FLT/FLE/FMIN/FMAX)         |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fcmp_core
  import fcmp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W    = 1 + EXP_W + MAN_W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [2:0]   i_op,
  output logic [W-1:0] o_result
);

  logic [1:0]   w_cls_a, w_cls_b;
  logic [W-2:0] w_mag_a, w_mag_b;
  logic         w_same, w_a_lt_b, w_b_lt_a, w_eq;

  assign w_mag_a = i_a[W-2:0];
  assign w_mag_b = i_b[W-2:0];
  assign w_cls_a = fcmp_class(i_a[W-1], i_a[W-2 -: EXP_W] == '0);
  assign w_cls_b = fcmp_class(i_b[W-1], i_b[W-2 -: EXP_W] == '0);
  assign w_same  = (w_cls_a == w_cls_b);
  assign w_eq    = w_same && ((w_cls_a == CLS_ZERO) || (w_mag_a == w_mag_b));

  // Within a class: positives ascend by magnitude, negatives descend, zeros tie.
  always_comb begin
    w_a_lt_b = (w_cls_a < w_cls_b);
    w_b_lt_a = (w_cls_b < w_cls_a);
    if (w_same && w_cls_a == CLS_POS) begin
      w_a_lt_b = (w_mag_a < w_mag_b);
      w_b_lt_a = (w_mag_b < w_mag_a);
    end else if (w_same && w_cls_a == CLS_NEG) begin
      w_a_lt_b = (w_mag_a > w_mag_b);
      w_b_lt_a = (w_mag_b > w_mag_a);
    end
  end

  // Ties in min/max always return operand a's raw bits.
  always_comb begin
    o_result = '0;
    case (i_op)
      FCMP_FEQ:  o_result = W'(w_eq);
      FCMP_FLT:  o_result = W'(w_a_lt_b);
      FCMP_FLE:  o_result = W'(w_a_lt_b | w_eq);
      FCMP_FMIN: o_result = w_b_lt_a ? i_b : i_a;
      FCMP_FMAX: o_result = w_a_lt_b ? i_b : i_a;
      default:   o_result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fcmp_pipe.sv
// +----------------------------------------------------------------------------+
// | fcmp_pipe : pipelined FP compare/select with valid/ready and tag carry      |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fcmp_pipe
  import fcmp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [W-1:0]     out_result
);

  generate
    if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
      $error("fcmp_pipe: STAGES must be in 1..3");
    end
  endgenerate

  logic [STAGES-1:0] r_valid;
  logic [TAG_W-1:0]  r_tag [STAGES];
  logic [W-1:0]      r_res [STAGES];
  logic [STAGES-1:0] w_free;
  logic [W-1:0]      w_core_result;

  fcmp_core #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_core (
    .i_a      (in_a),
    .i_b      (in_b),
    .i_op     (in_op),
    .o_result (w_core_result)
  );

  // Slot k can load when the consumer takes data or any slot from k onward has a hole.
  always_comb begin
    w_free = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_free[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!r_valid[j]) w_free[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_tag[k] <= '0;
        r_res[k] <= '0;
      end
    end else begin
      if (w_free[0]) begin
        r_valid[0] <= in_valid;
        if (in_valid) begin
          r_tag[0] <= in_tag;
          r_res[0] <= w_core_result;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_free[k]) begin
          r_valid[k] <= r_valid[k-1];
          if (r_valid[k-1]) begin
            r_tag[k] <= r_tag[k-1];
            r_res[k] <= r_res[k-1];
          end
        end
      end
    end
  end

  assign in_ready   = w_free[0];
  assign out_valid  = r_valid[STAGES-1];
  assign out_tag    = r_tag[STAGES-1];
  assign out_result = r_res[STAGES-1];

endmodule

`default_nettype wire

// File: tb/tb_fcmp_pipe.sv
// +----------------------------------------------------------------------------+
// | tb_fcmp_pipe : randomized self-checking bench for fcmp_pipe (default params) |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_fcmp_pipe;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int STAGES = 2;
  localparam int TAG_W  = 5;
  localparam int W      = 1 + EXP_W + MAN_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [W-1:0]     in_a, in_b, out_result;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [2:0]       op;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [TAG_W-1:0] tag;
    int               cyc;
  } acc_t;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     res;
    int               cyc;
  } out_t;

  acc_t acc_q[$];
  out_t got_q[$];

  fcmp_pipe #(
    .EXP_W  (EXP_W),
    .MAN_W  (MAN_W),
    .STAGES (STAGES),
    .TAG_W  (TAG_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_tag     (in_tag),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_tag    (out_tag),
    .out_result (out_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transfers are observed mid-cycle, where inputs and outputs are settled.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready)   acc_q.push_back('{in_op, in_a, in_b, in_tag, cyc});
      if (out_valid && out_ready) got_q.push_back('{out_tag, out_result, cyc});
    end
  end

  // Values map onto a signed integer line: zero class at 0, sign applied to magnitude.
  function automatic longint key(input logic [W-1:0] x);
    longint m;
    m = longint'(x[W-2:0]);
    if (x[W-2 -: EXP_W] == '0) return 0;
    return x[W-1] ? -m : m;
  endfunction

  function automatic logic [W-1:0] model_res(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint ka, kb;
    ka = key(a);
    kb = key(b);
    case (op)
      3'd0:    return W'(ka == kb);
      3'd1:    return W'(ka < kb);
      3'd2:    return W'(ka <= kb);
      3'd3:    return (kb < ka) ? b : a;
      3'd4:    return (ka < kb) ? b : a;
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] rand_near(input logic [W-1:0] a);
    logic [W-1:0] v;
    v = W'($urandom);
    case ($urandom_range(6))
      0: v = a;
      1: begin v = a; v[W-1] = ~v[W-1]; end
      2: v[W-2 -: EXP_W] = '0;
      3: v[W-2 -: EXP_W] = '1;
      4: v = a + W'(1);
      5: begin v = a; v[W-2 -: EXP_W] = '0; end
      default: ;
    endcase
    return v;
  endfunction

  task automatic rand_inputs();
    in_op  = ($urandom_range(99) < 85) ? 3'($urandom_range(4)) : 3'($urandom_range(7, 5));
    in_tag = TAG_W'($urandom);
    in_a   = rand_near(W'($urandom));
    in_b   = rand_near(in_a);
  endtask

  task automatic clear_queues();
    acc_q.delete();
    got_q.delete();
  endtask

  // Offers n requests (in_valid held until taken) with random valid/ready densities.
  task automatic stream(input int n, input int pv, input int pr, input bit fired0);
    int sent  = 0;
    int guard = 0;
    bit fired = fired0;
    while (sent < n && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
      if (fired) in_valid = 1'b0;
      if (!in_valid && $urandom_range(99) < pv) begin
        in_valid = 1'b1;
        rand_inputs();
      end
      out_ready = ($urandom_range(99) < pr);
      @(negedge clk);
      fired = in_valid && in_ready;
      if (fired) sent++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    out_ready = 1'b1;
    while (got_q.size() < acc_q.size() && g < 200) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_tag = '0; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_result !== '0) begin n_err++; $display("FAIL reset_out_result got %h want 0", out_result); end
    n_cmp++; if (out_tag !== '0) begin n_err++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]   vop  [7] = '{3'd1, 3'd1, 3'd0, 3'd2, 3'd1, 3'd3, 3'd4};
    logic [W-1:0] va   [7] = '{32'hBF800000, 32'hC0000000, 32'h80000000, 32'h80000000,
                               32'h80000000, 32'h00000000, 32'h40400000};
    logic [W-1:0] vb   [7] = '{32'h3F800000, 32'hBF800000, 32'h00000001, 32'h00000001,
                               32'h00000001, 32'h80000000, 32'h40A00000};
    logic [W-1:0] vexp [7] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h0, 32'h00000000, 32'h40A00000};
    logic [W-1:0] got_r;
    logic [TAG_W-1:0] got_t;
    for (int i = 0; i < 7; i++) begin
      int g = 0;
      clear_queues();
      @(posedge clk); #1;
      in_valid = 1'b1; out_ready = 1'b1;
      in_op = vop[i]; in_a = va[i]; in_b = vb[i]; in_tag = TAG_W'(i + 3);
      @(posedge clk); #1;
      in_valid = 1'b0;
      while (got_q.size() == 0 && g < 20) begin @(negedge clk); g++; end
      got_r = (got_q.size() > 0) ? got_q[0].res : 'x;
      got_t = (got_q.size() > 0) ? got_q[0].tag : 'x;
      n_cmp++;
      if (got_r !== vexp[i]) begin n_err++; $display("FAIL directed_%0d_result got %h want %h", i, got_r, vexp[i]); end
      n_cmp++;
      if (got_t !== TAG_W'(i + 3)) begin n_err++; $display("FAIL directed_%0d_tag got %h want %h", i, got_t, TAG_W'(i + 3)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_r;
    clear_queues();
    stream(8, 100, 100, 1'b0);
    drain();
    n_cmp++;
    if (got_q.size() !== 8) begin n_err++; $display("FAIL b2b_count got %0d want 8", got_q.size()); end
    if (got_q.size() == 8 && acc_q.size() == 8) begin
      n_cmp++;
      if (got_q[0].cyc - acc_q[0].cyc !== STAGES) begin
        n_err++; $display("FAIL b2b_latency got %0d want %0d", got_q[0].cyc - acc_q[0].cyc, STAGES);
      end
      for (int i = 0; i < 8; i++) begin
        exp_r = model_res(acc_q[i].op, acc_q[i].a, acc_q[i].b);
        n_cmp++;
        if (got_q[i].tag !== acc_q[i].tag || got_q[i].res !== exp_r) begin
          n_err++; $display("FAIL b2b_item_%0d got tag %h res %h want tag %h res %h",
                            i, got_q[i].tag, got_q[i].res, acc_q[i].tag, exp_r);
        end
        if (i > 0) begin
          n_cmp++;
          if (got_q[i].cyc !== got_q[i-1].cyc + 1 || acc_q[i].cyc !== acc_q[i-1].cyc + 1) begin
            n_err++; $display("FAIL b2b_rate_%0d got out cyc %0d acc cyc %0d want consecutive",
                              i, got_q[i].cyc, acc_q[i].cyc);
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0]     held_r, exp_r;
    logic [TAG_W-1:0] held_t;
    bit fired = 1'b0;
    clear_queues();
    out_ready = 1'b0;
    for (int c = 0; c < STAGES + 2; c++) begin
      @(posedge clk); #1;
      if (c == 0 || fired) begin in_valid = 1'b1; rand_inputs(); end
      @(negedge clk);
      fired = in_valid && in_ready;
    end
    n_cmp++;
    if (acc_q.size() !== STAGES || in_ready !== 1'b0) begin
      n_err++; $display("FAIL stall_fill got accepted %0d in_ready %b want %0d and 0", acc_q.size(), in_ready, STAGES);
    end
    held_r = out_result;
    held_t = out_tag;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== held_r || out_tag !== held_t) begin
        n_err++; $display("FAIL stall_hold_%0d got v %b rdy %b tag %h res %h want 1 0 %h %h",
                          c, out_valid, in_ready, out_tag, out_result, held_t, held_r);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_in_ready got %b want 1", in_ready); end
    fired = in_valid && in_ready;
    stream(5, 100, 100, fired);
    drain();
    n_cmp++;
    if (got_q.size() !== acc_q.size()) begin
      n_err++; $display("FAIL stall_count got %0d want %0d", got_q.size(), acc_q.size());
    end
    for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
      exp_r = model_res(acc_q[i].op, acc_q[i].a, acc_q[i].b);
      n_cmp++;
      if (got_q[i].tag !== acc_q[i].tag || got_q[i].res !== exp_r) begin
        n_err++; $display("FAIL stall_item_%0d got tag %h res %h want tag %h res %h",
                          i, got_q[i].tag, got_q[i].res, acc_q[i].tag, exp_r);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] exp_r;
    clear_queues();
    stream(150, 70, 60, 1'b0);
    drain();
    n_cmp++;
    if (got_q.size() !== acc_q.size()) begin
      n_err++; $display("FAIL random_count got %0d want %0d", got_q.size(), acc_q.size());
    end
    for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
      exp_r = model_res(acc_q[i].op, acc_q[i].a, acc_q[i].b);
      n_cmp++;
      if (got_q[i].tag !== acc_q[i].tag || got_q[i].res !== exp_r) begin
        n_err++; $display("FAIL random_item_%0d op %0d a %h b %h got tag %h res %h want tag %h res %h",
                          i, acc_q[i].op, acc_q[i].a, acc_q[i].b, got_q[i].tag, got_q[i].res,
                          acc_q[i].tag, exp_r);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int g = 0;
    logic [W-1:0]     got_r;
    logic [TAG_W-1:0] got_t;
    clear_queues();
    stream(2, 100, 0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; rand_inputs();
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || out_result !== '0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_state got v %b res %h rdy %b want 0 0 1", out_valid, out_result, in_ready);
    end
    clear_queues();
    @(posedge clk); #1;
    in_valid = 1'b1; out_ready = 1'b1;
    in_op = 3'd6; in_a = 32'h3F800000; in_b = 32'h40000000; in_tag = 5'h15;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (got_q.size() == 0 && g < 20) begin @(negedge clk); g++; end
    repeat (4) @(negedge clk);
    got_r = (got_q.size() > 0) ? got_q[0].res : 'x;
    got_t = (got_q.size() > 0) ? got_q[0].tag : 'x;
    n_cmp++;
    if (got_r !== '0 || got_t !== 5'h15) begin
      n_err++; $display("FAIL midrst_op6 got tag %h res %h want 15 0", got_t, got_r);
    end
    n_cmp++;
    if (got_q.size() !== 1) begin n_err++; $display("FAIL midrst_count got %0d want 1", got_q.size()); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
